uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds configurable data width, parity and stop-bit count. Each bit is decided by a 3-sample majority vote, and the block reports parity error, framing error and break. It sits between the serial pin and the byte-consuming logic, delivering one `rx_done` pulse per received character together with its status flags.

## Interface
- `FREQUENCY`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `PARITY`, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `CLKS_PER_BIT`, default FREQUENCY/BAUD_RATE: clocks per bit (derived); must be ≥ 8, checked at elaboration.
- `clk` in 1: single clock; every flop is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rx_serial` in 1: asynchronous serial line, idle high.
- `rx_done` out 1: one-cycle pulse; a character is complete and all outputs below are valid.
- `rx_byte` out DATA_BITS: received data, LSB first on the wire.
- `parity_err` out 1: parity check failed; always 0 when PARITY = 0.
- `frame_err` out 1: at least one stop bit was sampled low.
- `break_det` out 1: break character received.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** `rx_serial` passes through two flops (`s1`, `s2`). A third flop, `s_prev`, holds the previous `s2`. All three reset to 1.
- **Bit timing:** H = CLKS_PER_BIT/2, using integer division. The per-bit counter runs 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide. Samples of `s2` are taken at counter values H-1, H and H+1; the bit value is the majority of the three.
- **IDLE:**
  - A start edge is `s_prev`=1 and `s2`=0. On a start edge, go to START with the counter at 0.
  - A line that is low coming out of reset or out of a break is not a start. The line must be seen high first.
- **START:**
  - At counter H+1, evaluate the majority.
  - Majority 1 means a glitch: go to IDLE. No outputs change and there is no `rx_done`.
  - Otherwise, continue to counter CLKS_PER_BIT-1, then go to DATA with the bit index at 0.
- **DATA:**
  - Shift each majority value into position [bit index].
  - After the last counter value of bit DATA_BITS-1, go to PARITY if PARITY≠0, otherwise go to STOP.
- **PARITY:** Sample the parity bit the same way, then go to STOP.
  - Even mode: the XOR of the data bits and the parity bit must be 0.
  - Odd mode: that XOR must be 1.
- **STOP:**
  - Each stop bit is majority-sampled.
  - After sampling the last stop bit (at counter H+1), load all outputs and pulse `rx_done` on the next cycle, and return to IDLE at the same time. There is no wait for the bit end, so a new start edge can be accepted half a bit early; this tolerates TX/RX clock mismatch.
  - With 2 stop bits, the first one runs its full period.
- **Output flags:**
  - `frame_err` = 1 if any stop-bit majority was 0.
  - `break_det` = 1 if `frame_err` is set AND every data bit and the parity bit (if present) sampled 0.
  - On break, `rx_done` still pulses, with `frame_err`=1, `break_det`=1 and `parity_err` forced to 0.
- **Output hold:** `rx_byte`, `parity_err`, `frame_err` and `break_det` change only on the cycle `rx_done` rises and hold until the next `rx_done`.
- **Reset:**
  - Reset at any time, including mid-frame, forces IDLE.
  - All outputs go to 0, the counter and bit index clear, and the synchronizer goes to 1.
  - A partial frame is discarded with no `rx_done`.

## Timing
- **Reset values:** `rx_done`=0, `rx_byte`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `busy`=0.
- **Latency:**
  - Let e0 be the first rising edge that sees `rx_serial` low.
  - N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS is the number of bits in the frame.
  - `rx_done` is high during the cycle after edge e0 + 4 + H + CLKS_PER_BIT·(N-1).
  - This is exact, with no ±1 tolerance.
- **`busy` timing:** `busy` rises 2 cycles after e0. It falls in the same cycle that `rx_done` rises.
- **Back-to-back frames:** `rx_done` is never high on two consecutive cycles. The minimum spacing between `rx_done` pulses is one full frame.

## Test plan
- **8N1 data byte:** CLKS_PER_BIT=16, send 0xA5 at nominal rate → `rx_done` at e0+156, `rx_byte`=0xA5, all flags 0, a single-cycle pulse.
- **8E1 parity error:** send 0x03 with parity bit 1 → `parity_err`=1, `rx_byte`=0x03. Then send 0x03 with parity bit 0 → `parity_err`=0.
- **7O2 framing error:** send 0x55 with the second stop bit low → `frame_err`=1, `break_det`=0, `rx_byte`=0x55.
- **Start glitch and single-sample noise:**
  - Hold the line low for 3 cycles, then high → no `rx_done`, `busy` returns to 0.
  - Inject a 1-cycle spike at the middle of data bit 2 → majority vote still yields the correct byte.
- **Break then recovery:** hold the line low for 3 frame times, then high → one `rx_done` with `break_det`=1 and `frame_err`=1, no further `rx_done` while low. A following 0x3C is received cleanly.
- **Reset and back-to-back frames:**
  - Assert `reset` mid-DATA for 1 cycle → no `rx_done`, all outputs 0. The next full frame, 0x81, is received correctly.
  - Send 0x11 and 0x22 with zero idle time and the TX 2% fast → both bytes received, flags 0.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg -- configurable UART receiver
//
// Receives asynchronous serial frames of DATA_BITS data bits (LSB first),
// optional even/odd parity and one or two stop bits. Every bit is decided by
// a 3-sample majority vote around the bit centre. One rx_done pulse is
// produced per character, together with parity/framing/break status.
//
// Parameters:
//   FREQUENCY    clock frequency in Hz
//   BAUD_RATE    line rate in baud
//   DATA_BITS    data bits per frame, 5..9
//   PARITY       0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//   CLKS_PER_BIT clocks per bit, >= 8 (derived from FREQUENCY/BAUD_RATE)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   rx_serial   asynchronous serial input, idle high
//   rx_done     one-cycle pulse, character complete, outputs below valid
//   rx_byte     received data
//   parity_err  parity check failed (never set on a break)
//   frame_err   at least one stop bit sampled low
//   break_det   framing error with all data (and parity) bits low
//   busy        receiver is inside a frame
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int FREQUENCY    = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = FREQUENCY / BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  // Elaboration-time parameter checks.
  if (CLKS_PER_BIT < 8) begin : g_chk_cpb
    $error("uart_rx_cfg: CLKS_PER_BIT must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_sb
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_SAMP0 = CW'(H - 1);
  localparam logic [CW-1:0] CNT_SAMP1 = CW'(H);
  localparam logic [CW-1:0] CNT_EVAL  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          ODD_PARITY    = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   s1_q, s1_d;
  logic                   s2_q, s2_d;
  logic                   s_prev_q, s_prev_d;
  logic [1:0]             vld_q, vld_d;      // s2 carries a real line sample
  logic                   armed_q, armed_d;  // line has been seen high
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [1:0]             samp_q, samp_d;    // samples at H-1 and H
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   stop_err_q, stop_err_d;
  logic                   rx_done_q, rx_done_d;
  logic [DATA_BITS-1:0]   rx_byte_q, rx_byte_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   break_q, break_d;

  logic maj;
  logic at_eval;
  logic cnt_end;
  logic fe_now;
  logic brk_now;

  // Third sample is the live s2 at counter H+1, so the vote is ready on the
  // same cycle as the last sample.
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & s2_q) | (samp_q[1] & s2_q);
  assign at_eval = (cnt_q == CNT_EVAL);
  assign cnt_end = (cnt_q == CNT_LAST);

  // NOTE: every variable gets its default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    par_d        = par_q;
    stop_err_d   = stop_err_q;
    rx_done_d    = 1'b0;
    rx_byte_d    = rx_byte_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_d      = break_q;
    fe_now       = stop_err_q | ~maj;
    brk_now      = fe_now && (shift_q == '0) && ((PARITY == 0) || !par_q);

    s1_d     = rx_serial;
    s2_d     = s1_q;
    s_prev_d = s2_q;
    vld_d    = {vld_q[0], 1'b1};
    armed_d  = armed_q | (vld_q[1] & s2_q);

    if (state_q != ST_IDLE) begin
      cnt_d = cnt_end ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_SAMP0) samp_d[0] = s2_q;
      if (cnt_q == CNT_SAMP1) samp_d[1] = s2_q;
    end

    case (state_q)
      ST_IDLE: begin
        // A low line right after reset or a break never counts as a start.
        if (armed_q && s_prev_q && !s2_q) begin
          state_d    = ST_START;
          cnt_d      = '0;
          stop_err_d = 1'b0;
        end
      end

      ST_START: begin
        if (at_eval && maj) begin
          state_d = ST_IDLE;  // glitch: start bit did not hold
          cnt_d   = '0;
        end else if (cnt_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end

      ST_DATA: begin
        if (at_eval) shift_d[idx_q] = maj;
        if (cnt_end) begin
          if (idx_q == IDX_LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (at_eval) par_d = maj;
        if (cnt_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end

      ST_STOP: begin
        if (at_eval) begin
          stop_err_d = fe_now;
          if (idx_q == IDX_LAST_STOP) begin
            // Finish at the centre of the last stop bit so a slightly fast
            // transmitter's next start edge is not missed.
            state_d      = ST_IDLE;
            cnt_d        = '0;
            idx_d        = '0;
            rx_done_d    = 1'b1;
            rx_byte_d    = shift_q;
            frame_err_d  = fe_now;
            break_d      = brk_now;
            parity_err_d = (PARITY != 0) && !brk_now &&
                           ((^shift_q ^ par_q) != ODD_PARITY);
          end
        end else if (cnt_end) begin
          idx_d = idx_q + IW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      s_prev_q     <= 1'b1;
      vld_q        <= '0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_err_q   <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_byte_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s_prev_q     <= s_prev_d;
      vld_q        <= vld_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop_err_q   <= stop_err_d;
      rx_done_q    <= rx_done_d;
      rx_byte_q    <= rx_byte_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
    end
  end

  assign rx_done    = rx_done_q;
  assign rx_byte    = rx_byte_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg -- self-checking bench for uart_rx_cfg
//
// Three receivers (8N1, 8E1, 7O2, all 16 clocks per bit) share a clock and
// reset; a single transmitter line is steered to one of them. Expected data,
// flags and rx_done timing come from a frame-level model of the protocol.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

  localparam int C = 16;
  localparam int H = C / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx = 1'b1;
  int   sel = 0;
  int   cyc = 0;

  logic [2:0] rx_w;
  logic [2:0] done_w, busy_w, pe_w, fe_w, bk_w;
  logic [7:0] byte0, byte1;
  logic [6:0] byte2;
  logic [8:0] byte_w [3];

  assign rx_w[0] = (sel == 0) ? tx : 1'b1;
  assign rx_w[1] = (sel == 1) ? tx : 1'b1;
  assign rx_w[2] = (sel == 2) ? tx : 1'b1;
  assign byte_w[0] = {1'b0, byte0};
  assign byte_w[1] = {1'b0, byte1};
  assign byte_w[2] = {2'b00, byte2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(C)) u_8n1 (
    .clk(clk), .reset(reset), .rx_serial(rx_w[0]), .rx_done(done_w[0]),
    .rx_byte(byte0), .parity_err(pe_w[0]), .frame_err(fe_w[0]),
    .break_det(bk_w[0]), .busy(busy_w[0]));

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(C)) u_8e1 (
    .clk(clk), .reset(reset), .rx_serial(rx_w[1]), .rx_done(done_w[1]),
    .rx_byte(byte1), .parity_err(pe_w[1]), .frame_err(fe_w[1]),
    .break_det(bk_w[1]), .busy(busy_w[1]));

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(C)) u_7o2 (
    .clk(clk), .reset(reset), .rx_serial(rx_w[2]), .rx_done(done_w[2]),
    .rx_byte(byte2), .parity_err(pe_w[2]), .frame_err(fe_w[2]),
    .break_det(bk_w[2]), .busy(busy_w[2]));

  // ---------------- event monitor ----------------
  typedef struct {
    int         dut;
    int         cyc;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } ev_t;

  ev_t  evq[$];
  logic [2:0] prev_done = '0;
  logic [2:0] prev_busy = '0;
  int   busy_rise [3];
  int   busy_fall [3];
  int   dbl_cnt = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_w[k]) begin
        evq.push_back('{k, cyc, byte_w[k], pe_w[k], fe_w[k], bk_w[k]});
        if (prev_done[k]) dbl_cnt <= dbl_cnt + 1;
      end
      if (busy_w[k] && !prev_busy[k]) busy_rise[k] <= cyc;
      if (!busy_w[k] && prev_busy[k]) busy_fall[k] <= cyc;
    end
    prev_done <= done_w;
    prev_busy <= busy_w;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] out_vec(input int k);
    return {done_w[k], busy_w[k], pe_w[k], fe_w[k], bk_w[k], byte_w[k]};
  endfunction

  // Frame-level model: config k -> data width, parity mode, stop count.
  // Returns the wire bits (index 0 first) and the expected result.
  function automatic int build(input int s, input logic [8:0] din, input logic pflip,
                               input logic [1:0] stops, output logic [15:0] bits,
                               output logic [8:0] d, output logic pe,
                               output logic fe, output logic bk);
    int   db, pm, sb, n;
    logic p;
    db = (s == 2) ? 7 : 8;
    pm = s;
    sb = (s == 2) ? 2 : 1;
    d  = din & ((9'd1 << db) - 9'd1);
    // Correct parity makes XOR(data, parity) equal 1 for odd, 0 for even.
    p  = ((pm == 2) ? 1'b1 : 1'b0) ^ (^d) ^ pflip;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < db; i++) bits[1+i] = d[i];
    n = 1 + db;
    if (pm != 0) begin
      bits[n] = p;
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      bits[n] = stops[i];
      n++;
    end
    fe = (sb == 2) ? !(stops[0] && stops[1]) : !stops[0];
    bk = fe && (d == 0) && (pm == 0 || p == 1'b0);
    pe = (pm != 0) && !bk && pflip;
    return n;
  endfunction

  // Drives n bits of C clocks each, stretched by 100/speed. spike_t inverts
  // the line for one cycle; rst_t pulses reset for one cycle.
  task automatic send_bits(input logic [31:0] bits, input int n, input int speed,
                           input int spike_t, input int rst_t, output int e0);
    int total;
    int b;
    total = (n * C * 100 + speed - 1) / speed;
    @(posedge clk); #1;
    e0 = cyc + 1;
    for (int t = 0; t < total; t++) begin
      b = (t * speed) / (C * 100);
      if (b > n - 1) b = n - 1;
      tx    = bits[b] ^ (t == spike_t);
      reset = (t == rst_t);
      @(posedge clk); #1;
    end
    tx    = 1'b1;
    reset = 1'b0;
  endtask

  task automatic expect_ev(input string tag, input int s, input int e0, input int n,
                           input logic [8:0] d, input logic pe, input logic fe,
                           input logic bk);
    ev_t ev;
    int  waited;
    waited = 0;
    while (evq.size() == 0 && waited < 4 * C) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_done"}, (evq.size() != 0), 1);
    if (evq.size() != 0) begin
      ev = evq.pop_front();
      check({tag, "_dut"}, ev.dut, s);
      if (e0 >= 0) begin
        check({tag, "_latency"}, ev.cyc, e0 + 4 + H + C * (n - 1));
        check({tag, "_busy_rise"}, busy_rise[s], e0 + 2);
        check({tag, "_busy_fall"}, busy_fall[s], ev.cyc);
      end
      check({tag, "_byte"}, ev.data, d);
      check({tag, "_perr"}, ev.pe, pe);
      check({tag, "_ferr"}, ev.fe, fe);
      check({tag, "_brk"}, ev.bk, bk);
    end
  endtask

  task automatic expect_none(input string tag, input int cycles);
    repeat (cycles) @(negedge clk);
    check(tag, evq.size(), 0);
    evq.delete();
  endtask

  task automatic run_frame(input string tag, input int s, input logic [8:0] din,
                           input logic pflip, input logic [1:0] stops, input int spike_t);
    logic [15:0] bits;
    logic [8:0]  d;
    logic        pe, fe, bk;
    int          n, e0;
    sel = s;
    n = build(s, din, pflip, stops, bits, d, pe, fe, bk);
    send_bits({16'hFFFF, bits}, n, 100, spike_t, -1, e0);
    expect_ev(tag, s, e0, n, d, pe, fe, bk);
    repeat ($urandom_range(2, 12)) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] b1, b2;
    logic [8:0]  d1, d2;
    logic        pe, fe, bk;
    int          n, e0;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("reset_out%0d", k), out_vec(k), 0);
    reset = 1'b0;
    repeat (40) @(posedge clk);

    // 8N1 nominal byte
    run_frame("8n1_a5", 0, 9'h0A5, 1'b0, 2'b11, -1);

    // 8E1 wrong then right parity bit
    run_frame("8e1_bad_par", 1, 9'h003, 1'b1, 2'b11, -1);
    run_frame("8e1_good_par", 1, 9'h003, 1'b0, 2'b11, -1);

    // 7O2 second stop bit low
    run_frame("7o2_ferr", 2, 9'h055, 1'b0, 2'b01, -1);

    // Start glitch: 3 low cycles
    sel = 0;
    @(posedge clk); #1;
    tx = 1'b0;
    e0 = cyc + 1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    tx = 1'b1;
    expect_none("glitch_no_done", 2 * C);
    check("glitch_busy_rise", busy_rise[0], e0 + 2);
    check("glitch_busy_idle", busy_w[0], 0);
    check("glitch_byte_hold", byte_w[0], 9'h0A5);

    // One-cycle spike on the middle sample of data bit 2
    run_frame("spike", 0, 9'h0B4, 1'b0, 2'b11, 3 * C + H + 1);

    // Break: line low for 3 frames, then a clean byte
    sel = 0;
    send_bits(32'h0, 30, 100, -1, -1, e0);
    expect_ev("break", 0, e0, 10, 9'h000, 1'b0, 1'b1, 1'b1);
    expect_none("break_single", 2 * C);
    repeat (20) @(posedge clk);
    run_frame("after_break", 0, 9'h03C, 1'b0, 2'b11, -1);

    // Odd-parity break: parity bit low would be a parity error, but break wins
    run_frame("7o2_break", 2, 9'h000, 1'b1, 2'b00, -1);

    // Reset pulse in the middle of data
    sel = 0;
    n = build(0, 9'h05A, 1'b0, 2'b11, b1, d1, pe, fe, bk);
    send_bits({16'hFFFF, b1}, 6, 100, -1, 5 * C + 3, e0);
    expect_none("reset_no_done", 3 * C);
    check("reset_mid_out", out_vec(0), 0);
    run_frame("after_reset", 0, 9'h081, 1'b0, 2'b11, -1);

    // Back-to-back, transmitter 2% fast
    sel = 0;
    n = build(0, 9'h011, 1'b0, 2'b11, b1, d1, pe, fe, bk);
    n = build(0, 9'h022, 1'b0, 2'b11, b2, d2, pe, fe, bk);
    send_bits({2'b11, b2[9:0], b1[9:0]} | 32'hFFF0_0000, 20, 102, -1, -1, e0);
    expect_ev("b2b_first", 0, -1, 10, d1, 1'b0, 1'b0, 1'b0);
    expect_ev("b2b_second", 0, -1, 10, d2, 1'b0, 1'b0, 1'b0);
    expect_none("b2b_extra", C);

    // Randomized frames across all three configurations
    for (int i = 0; i < 15; i++) begin
      int          s;
      logic [8:0]  din;
      logic        pf;
      logic [1:0]  st;
      s   = $urandom_range(0, 2);
      din = 9'($urandom);
      if ($urandom_range(0, 7) == 0) din = '0;
      pf  = ($urandom_range(0, 3) == 0);
      st  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      run_frame($sformatf("rand%0d", i), s, din, pf, st, -1);
    end

    check("no_double_pulse", dbl_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
